// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - DXYN sprite draw engine: RAM byte fetch and VRAM XOR read-modify-write
//
// Purpose:
//   Executes one CHIP-8 / SCHIP / XO-CHIP DXYN draw. Sprite rows are fetched
//   from RAM one byte at a time, each set bit is XORed into the selected VRAM
//   plane by a read-modify-write, and any plane bit that was already set
//   raises the collision (VF) result. Acts as the writer end of the VRAM
//   pixel port while busy is high.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle draw request, accepted only when idle
//   x, y                raw VX / VY, reduced modulo the screen size at start
//   n                   sprite height, 0 selects a 16x16 sprite
//   i_addr              address of the first sprite byte
//   hires               1 = 128x64 screen, 0 = 64x32 (top-left of VRAM)
//   plane_mask          bit k enables plane k
//   busy, done          handshake: busy during the draw, done one-cycle pulse
//   collision           VF result, updated with done
//   ram_addr, ram_dout  sprite fetch port, data one cycle after address
//   vram_hpos/vpos      VRAM pixel address
//   vram_pixeli/we      VRAM write data and strobe
//   vram_pixelo         VRAM read data, one cycle after address

module sprite_blitter #(
   parameter int ADDR_W = 16,
   parameter int HRES_W = 7,
   parameter int VRES_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        x,
   input  logic [7:0]        y,
   input  logic [3:0]        n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              hires,
   input  logic [1:0]        plane_mask,
   output logic              busy,
   output logic              done,
   output logic              collision,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_dout,
   output logic [HRES_W-1:0] vram_hpos,
   output logic [VRES_W-1:0] vram_vpos,
   output logic [1:0]        vram_pixeli,
   input  logic [1:0]        vram_pixelo,
   output logic              vram_we
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FWAIT,
      S_PIX,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   // Modulo masks for the raw VX / VY values in each resolution.
   localparam logic [7:0] X_MASK_HI = 8'((1 << HRES_W) - 1);
   localparam logic [7:0] X_MASK_LO = 8'((1 << (HRES_W - 1)) - 1);
   localparam logic [7:0] Y_MASK_HI = 8'((1 << VRES_W) - 1);
   localparam logic [7:0] Y_MASK_LO = 8'((1 << (VRES_W - 1)) - 1);

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_coll;
   logic              r_coll_acc;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [HRES_W-1:0] r_hpos;
   logic [VRES_W-1:0] r_vpos;
   logic [7:0]        r_x0;
   logic [7:0]        r_y0;
   logic              r_wide;
   logic [4:0]        r_rows;
   logic              r_hires;
   logic [1:0]        r_mask;
   logic              r_plane;
   logic [4:0]        r_row;
   logic [4:0]        r_col;
   logic              r_hi_done;
   logic [15:0]       r_shift;

   logic [7:0]        w_px;
   logic [7:0]        w_py;
   logic [8:0]        w_scr_w;
   logic [8:0]        w_scr_h;
   logic              w_vis;
   logic              w_row_end;
   logic              w_more_rows;
   logic [1:0]        w_plane_bit;

   // Absolute pixel position; one bit wider than VRAM so that positions
   // past the right/bottom edge are clipped instead of wrapping.
   assign w_px        = r_x0 + {3'b000, r_col};
   assign w_py        = r_y0 + {3'b000, r_row};
   assign w_scr_w     = r_hires ? 9'(1 << HRES_W) : 9'(1 << (HRES_W - 1));
   assign w_scr_h     = r_hires ? 9'(1 << VRES_W) : 9'(1 << (VRES_W - 1));
   assign w_vis       = ({1'b0, w_px} < w_scr_w) && ({1'b0, w_py} < w_scr_h);
   assign w_row_end   = (r_col == (r_wide ? 5'd16 : 5'd8));
   assign w_more_rows = ((r_row + 5'd1) < r_rows);
   assign w_plane_bit = r_plane ? 2'b10 : 2'b01;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_coll     <= 1'b0;
         r_coll_acc <= 1'b0;
         r_ram_addr <= '0;
         r_hpos     <= '0;
         r_vpos     <= '0;
         r_x0       <= '0;
         r_y0       <= '0;
         r_wide     <= 1'b0;
         r_rows     <= '0;
         r_hires    <= 1'b0;
         r_mask     <= '0;
         r_plane    <= 1'b0;
         r_row      <= '0;
         r_col      <= '0;
         r_hi_done  <= 1'b0;
         r_shift    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy     <= 1'b1;
                  r_coll_acc <= 1'b0;
                  r_ram_addr <= i_addr;
                  r_x0       <= x & (hires ? X_MASK_HI : X_MASK_LO);
                  r_y0       <= y & (hires ? Y_MASK_HI : Y_MASK_LO);
                  r_wide     <= (n == 4'd0);
                  r_rows     <= (n == 4'd0) ? 5'd16 : {1'b0, n};
                  r_hires    <= hires;
                  r_mask     <= plane_mask;
                  // First enabled plane; with no plane enabled the draw
                  // goes straight to DONE and this value is never used.
                  r_plane    <= ~plane_mask[0];
                  r_row      <= '0;
                  r_col      <= '0;
                  r_hi_done  <= 1'b0;
                  r_state    <= (plane_mask == 2'b00) ? S_DONE : S_FETCH;
               end
            end

            S_FETCH: begin
               // Address was presented this cycle; plane data is contiguous,
               // so the pointer simply runs forward across rows and planes.
               r_ram_addr <= r_ram_addr + ADDR_W'(1);
               r_state    <= S_FWAIT;
            end

            S_FWAIT: begin
               if (r_wide && !r_hi_done) begin
                  r_shift[15:8] <= ram_dout;
                  r_hi_done     <= 1'b1;
                  r_state       <= S_FETCH;
               end else begin
                  if (r_wide) begin
                     r_shift[7:0] <= ram_dout;
                  end else begin
                     r_shift <= {ram_dout, 8'h00};
                  end
                  r_hi_done <= 1'b0;
                  r_col     <= '0;
                  r_state   <= S_PIX;
               end
            end

            S_PIX: begin
               if (w_row_end) begin
                  if (w_more_rows) begin
                     r_row   <= r_row + 5'd1;
                     r_state <= S_FETCH;
                  end else if (!r_plane && r_mask[1]) begin
                     r_plane <= 1'b1;
                     r_row   <= '0;
                     r_state <= S_FETCH;
                  end else begin
                     r_state <= S_DONE;
                  end
               end else begin
                  r_shift <= {r_shift[14:0], 1'b0};
                  r_col   <= r_col + 5'd1;
                  if (r_shift[15] && w_vis) begin
                     r_hpos  <= w_px[HRES_W-1:0];
                     r_vpos  <= w_py[VRES_W-1:0];
                     r_state <= S_RD;
                  end
               end
            end

            S_RD: begin
               r_state <= S_WR;
            end

            S_WR: begin
               if (vram_pixelo[r_plane]) begin
                  r_coll_acc <= 1'b1;
               end
               r_state <= S_PIX;
            end

            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_coll  <= r_coll_acc;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign collision = r_coll;
   assign ram_addr  = r_ram_addr;
   assign vram_hpos = r_hpos;
   assign vram_vpos = r_vpos;

   // The read data only arrives in the WR cycle, so the write data and strobe
   // are decoded from the state register rather than registered a cycle
   // ahead; this keeps a visible set bit at three cycles.
   assign vram_we     = (r_state == S_WR);
   assign vram_pixeli = vram_pixelo ^ w_plane_bit;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter against a cycle-schedule model

module tb_sprite_blitter;

   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  x_i;
   logic [7:0]  y_i;
   logic [3:0]  n_i;
   logic [15:0] ia_i;
   logic        hires_i;
   logic [1:0]  pm_i;
   logic        busy;
   logic        done;
   logic        collision;
   logic [15:0] ram_addr;
   logic [7:0]  ram_dout;
   logic [6:0]  hpos;
   logic [5:0]  vpos;
   logic [1:0]  pixeli;
   logic [1:0]  pixelo;
   logic        we;

   sprite_blitter dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .x           (x_i),
      .y           (y_i),
      .n           (n_i),
      .i_addr      (ia_i),
      .hires       (hires_i),
      .plane_mask  (pm_i),
      .busy        (busy),
      .done        (done),
      .collision   (collision),
      .ram_addr    (ram_addr),
      .ram_dout    (ram_dout),
      .vram_hpos   (hpos),
      .vram_vpos   (vpos),
      .vram_pixeli (pixeli),
      .vram_pixelo (pixelo),
      .vram_we     (we)
   );

   always #5 clk = ~clk;

   // Environment memories (synchronous read, one cycle latency).
   logic [7:0] ram_mem [0:65535];
   logic [7:0] ram_q;
   logic [1:0] vram_mem [0:127][0:63];
   logic [1:0] vram_q;

   always @(posedge clk) begin
      ram_q  <= ram_mem[ram_addr];
      vram_q <= vram_mem[hpos][vpos];
      if (we) vram_mem[hpos][vpos] <= pixeli;
   end
   assign ram_dout = ram_q;
   assign pixelo   = vram_q;

   // Reference model state: expected screen and per-cycle expectations.
   logic [1:0]  mv [0:127][0:63];
   bit          e_busy  [0:MAXC-1];
   bit          e_done  [0:MAXC-1];
   bit          e_we    [0:MAXC-1];
   bit          e_fetch [0:MAXC-1];
   int          e_h     [0:MAXC-1];
   int          e_v     [0:MAXC-1];
   logic [1:0]  e_px    [0:MAXC-1];
   logic [15:0] e_addr  [0:MAXC-1];
   int          e_len;
   int          e_nfetch;
   bit          e_coll;

   int          n_checks = 0;
   int          n_fail = 0;
   bit          chk_on = 0;
   bit          idle_chk = 0;
   int          cj = 0;
   logic [1:0]  wlog [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Cost rules: each byte fetch 2 cycles, a set visible bit 3 cycles (write
   // in the third), any other bit 1 cycle, 1 cycle at each row end, then one
   // busy cycle before done.
   task automatic build_model(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                              input logic [15:0] di, input logic dh, input logic [1:0] dm);
      int sw, sh, x0, y0, rows, bpr, t, h, v;
      logic [15:0] ptr, bits;
      logic [1:0]  old;
      bit          coll;
      sw = dh ? 128 : 64;
      sh = dh ? 64 : 32;
      x0 = int'(dx) % sw;
      y0 = int'(dy) % sh;
      rows = (dn == 4'd0) ? 16 : int'(dn);
      bpr = (dn == 4'd0) ? 2 : 1;
      for (int i = 0; i < MAXC; i++) begin
         e_busy[i] = 0; e_done[i] = 0; e_we[i] = 0; e_fetch[i] = 0;
         e_h[i] = 0; e_v[i] = 0; e_px[i] = 2'b00; e_addr[i] = 16'h0;
      end
      ptr = di; t = 0; coll = 0; e_nfetch = 0;
      for (int p = 0; p < 2; p++) begin
         if (dm[p]) begin
            for (int r = 0; r < rows; r++) begin
               bits = 16'h0;
               for (int b = 0; b < bpr; b++) begin
                  e_fetch[t] = 1; e_addr[t] = ptr; e_nfetch++;
                  bits = {bits[7:0], ram_mem[ptr]};
                  ptr = ptr + 16'd1;
                  t += 2;
               end
               if (bpr == 1) bits = bits << 8;
               for (int c = 0; c < 8 * bpr; c++) begin
                  if (bits[15-c] && (x0 + c < sw) && (y0 + r < sh)) begin
                     h = x0 + c; v = y0 + r;
                     t += 2;
                     old = mv[h][v];
                     if (old[p]) coll = 1;
                     e_we[t] = 1; e_h[t] = h; e_v[t] = v;
                     e_px[t] = old ^ (2'b01 << p);
                     mv[h][v] = e_px[t];
                     t++;
                  end else begin
                     t++;
                  end
               end
               t++;
            end
         end
      end
      for (int i = 0; i <= t; i++) e_busy[i] = 1;
      e_done[t+1] = 1;
      e_len = t + 2;
      e_coll = coll;
   endtask

   always @(negedge clk) begin
      if (!reset && we) wlog.push_back(pixeli);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk($sformatf("busy[%0d]", cj), busy, e_busy[cj]);
         chk($sformatf("done[%0d]", cj), done, e_done[cj]);
         chk($sformatf("we[%0d]", cj), we, e_we[cj]);
         if (e_we[cj]) begin
            chk($sformatf("hpos[%0d]", cj), hpos, e_h[cj]);
            chk($sformatf("vpos[%0d]", cj), vpos, e_v[cj]);
            chk($sformatf("pixeli[%0d]", cj), pixeli, e_px[cj]);
         end
         if (e_fetch[cj]) chk($sformatf("ram_addr[%0d]", cj), ram_addr, e_addr[cj]);
         if (e_done[cj]) chk("collision_at_done", collision, e_coll);
         cj++;
         if (cj >= e_len) chk_on = 0;
      end else if (idle_chk && !reset) begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_we", we, 0);
      end
   end

   task automatic do_draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                          input logic [15:0] di, input logic dh, input logic [1:0] dm, input int poke);
      @(posedge clk); #1;
      build_model(dx, dy, dn, di, dh, dm);
      x_i = dx; y_i = dy; n_i = dn; ia_i = di; hires_i = dh; pm_i = dm;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      wlog.delete();
      cj = 0;
      chk_on = 1;
      if (poke > 0) begin
         repeat (poke) @(posedge clk);
         #1; x_i = ~dx; start = 1;
         @(posedge clk); #1; start = 0;
      end
      for (int k = 0; k < MAXC + 8 && chk_on; k++) @(posedge clk);
      if (chk_on) begin
         n_checks++; n_fail++;
         $display("FAIL draw_timeout: compare still active after %0d cycles", MAXC + 8);
         chk_on = 0;
      end
      @(posedge clk); #1;
   endtask

   int mism;

   initial begin
      reset = 1; start = 0; x_i = 0; y_i = 0; n_i = 0; ia_i = 0; hires_i = 0; pm_i = 0;
      for (int i = 0; i < 65536; i++) ram_mem[i] = 8'($urandom);
      for (int h = 0; h < 128; h++)
         for (int v = 0; v < 64; v++) begin
            vram_mem[h][v] = 2'b00;
            mv[h][v] = 2'b00;
         end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_collision", collision, 0);
      chk("rst_we", we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_hpos", hpos, 0);
      chk("rst_vpos", vpos, 0);
      @(posedge clk); #1;
      reset = 0;
      idle_chk = 1;

      // Draw 1 and its redraw.
      ram_mem[16'h0200] = 8'hF0;
      do_draw(8'd0, 8'd0, 4'd1, 16'h0200, 1'b0, 2'b01, 0);
      chk("model_done_latency", e_len - 1, 20);
      for (int c = 0; c < 4; c++) chk($sformatf("draw1_px%0d", c), vram_mem[c][0], 1);
      chk("draw1_writes", wlog.size(), 4);
      chk("draw1_collision", collision, 0);
      do_draw(8'd0, 8'd0, 4'd1, 16'h0200, 1'b0, 2'b01, 0);
      for (int c = 0; c < 4; c++) chk($sformatf("redraw_px%0d", c), vram_mem[c][0], 0);
      chk("redraw_collision", collision, 1);

      // Modulo origin and bottom clipping.
      ram_mem[16'h0300] = 8'hFF;
      ram_mem[16'h0301] = 8'hFF;
      do_draw(8'h42, 8'h1F, 4'd2, 16'h0300, 1'b0, 2'b01, 0);
      chk("clip_writes", wlog.size(), 8);
      for (int c = 2; c < 10; c++) chk($sformatf("clip_row31_px%0d", c), vram_mem[c][31], 1);
      chk("clip_no_wrap_row0", vram_mem[2][0], 0);

      // Two planes on one pixel.
      ram_mem[16'h0500] = 8'h80;
      ram_mem[16'h0501] = 8'h80;
      do_draw(8'd20, 8'd10, 4'd1, 16'h0500, 1'b0, 2'b11, 0);
      chk("planes_writes", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("planes_first", wlog[0], 2'b01);
         chk("planes_second", wlog[1], 2'b11);
      end
      chk("planes_final", vram_mem[20][10], 2'b11);

      // Hires 16x16 at the right edge, with a start pulse while busy.
      for (int i = 0; i < 32; i++) ram_mem[16'h0600 + i] = 8'hFF;
      do_draw(8'd120, 8'd0, 4'd0, 16'h0600, 1'b1, 2'b01, 8);
      chk("hires_fetches", e_nfetch, 32);
      chk("hires_writes", wlog.size(), 128);
      chk("hires_corner", vram_mem[127][15], 1);
      chk("hires_collision", collision, 0);

      // Empty plane mask and address wrap at 0xFFFF.
      do_draw(8'd5, 8'd5, 4'd3, 16'h0100, 1'b0, 2'b00, 0);
      chk("nomask_collision", collision, 0);
      ram_mem[16'hFFFF] = 8'h81;
      ram_mem[16'h0000] = 8'h42;
      do_draw(8'd40, 8'd3, 4'd2, 16'hFFFF, 1'b0, 2'b10, 0);

      for (int i = 0; i < 20; i++)
         do_draw(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);

      mism = 0;
      for (int h = 0; h < 128; h++)
         for (int v = 0; v < 64; v++)
            if (vram_mem[h][v] !== mv[h][v]) mism++;
      chk("vram_image_mismatches", mism, 0);

      // Leave collision set so the reset clear is observable.
      ram_mem[16'h0700] = 8'h80;
      do_draw(8'd63, 8'd31, 4'd1, 16'h0700, 1'b0, 2'b01, 0);
      if (!e_coll) do_draw(8'd63, 8'd31, 4'd1, 16'h0700, 1'b0, 2'b01, 0);
      chk("coll_before_reset", collision, 1);

      // Reset in the middle of a row.
      @(posedge clk); #1;
      idle_chk = 0;
      x_i = 8'd30; y_i = 8'd5; n_i = 4'd4; ia_i = 16'h0600; hires_i = 1'b0; pm_i = 2'b01;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (6) @(posedge clk);
      #1; reset = 1;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_busy", busy, 0);
      chk("midreset_we", we, 0);
      chk("midreset_collision", collision, 0);
      chk("midreset_done", done, 0);
      chk("midreset_ram_addr", ram_addr, 0);

      // Start coinciding with reset is ignored.
      start = 1;
      @(posedge clk); #1;
      reset = 0;
      start = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("start_with_reset_busy%0d", k), busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Executes the CHIP-8 / SCHIP / XO-CHIP DXYN draw. Fetches sprite bytes from RAM and XORs them into the 128x64 2-bit-per-pixel VRAM by read-modify-write. Reports collision in VF.
- Acts as the writer end of the VRAM pixel port; vdrive is the reader end.
- The cpu hands off the draw with start/busy/done and muxes its RAM and VRAM ports to this block while busy=1.

Parameters:
- ADDR_W, 16, RAM byte address width.
- HRES_W, 7, VRAM column index width (128 columns).
- VRES_W, 6, VRAM row index width (64 rows).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle draw request; sampled only in IDLE
- x  in  8  VX value, raw (unwrapped)
- y  in  8  VY value, raw (unwrapped)
- n  in  4  sprite height; 0 selects a 16x16 sprite
- i_addr  in  16  I register, address of the first sprite byte
- hires  in  1  1 selects a 128x64 screen; 0 selects 64x32 (top-left of VRAM)
- plane_mask  in  2  XO-CHIP plane select; bit k enables plane k
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the draw completes
- collision  out  1  VF result; valid from done, held until the next accepted start
- ram_addr  out  16  sprite fetch address
- ram_dout  in  8  RAM read data, valid 1 cycle after ram_addr
- vram_hpos  out  7  VRAM column
- vram_vpos  out  6  VRAM row
- vram_pixeli  out  2  pixel written to VRAM
- vram_pixelo  in  2  VRAM read data, valid 1 cycle after hpos/vpos
- vram_we  out  1  VRAM write strobe

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, collision=0, vram_we=0; all address outputs 0.
  - Reset mid-draw aborts immediately; pixels already written are kept.
- Screen size: W=128, H=64 when hires=1; W=64, H=32 when hires=0.
- Origin: x0 = x mod W, y0 = y mod H, both latched at start together with n, i_addr, hires and plane_mask.
- Clipping: a pixel is drawn only if x0+col < W and y0+row < H. There is no wrap inside the sprite.
- Sprite shape:
  - n≠0: 8 pixels wide, n rows, 1 byte per row.
  - n=0: 16 wide, 16 rows, 2 bytes per row (high byte = left 8 pixels).
  - Bytes per plane: B = n, or 32 when n=0.
- Planes:
  - Enabled planes are processed in order plane 0 then plane 1.
  - Plane data is consecutive: the first enabled plane uses i_addr..i_addr+B-1, the next uses i_addr+B onward.
  - plane_mask=0: no fetches, no writes; done is pulsed 2 cycles after start with collision=0.
- State machine:
  - IDLE: on start, go to FETCH and assert busy.
  - FETCH: drive ram_addr, go to FWAIT.
  - FWAIT: latch ram_dout into the shift register. For 16-wide rows, fetch the second byte via FETCH again before moving on. Go to PIX.
  - PIX: take the sprite bit MSB-first.
    - Bit 0 or pixel clipped: advance (1 cycle).
    - Otherwise drive hpos/vpos and go to RD.
  - RD: wait one cycle for vram_pixelo.
  - WR:
    - vram_pixeli = vram_pixelo XOR (1<<plane), vram_we=1 for 1 cycle.
    - If that plane bit was 1 before the write, set the collision accumulator.
    - Return to PIX.
  - Row end goes to FETCH for the next row. The last row of the last plane goes to DONE.
  - DONE: pulse done, publish collision, drop busy, go to IDLE.
- Timing: a set, visible bit costs 3 cycles; a clear or clipped bit costs 1 cycle; each byte fetch costs 2 cycles.
- vram_we is asserted only in WR. ram_addr is 16-bit and wraps at 0xFFFF.
- start while busy is ignored. start coinciding with reset is ignored.
- Collision is computed across all enabled planes.

Test Plan:
- Draw 1 (lores, plane_mask=01, x=0, y=0, n=1, RAM[0x200]=0xF0, clear VRAM):
  - 4 VRAM writes of 01 to (0..3, 0).
  - done pulses 4+4*3+4 cycles after busy rises.
  - collision=0.
- Redraw of the same sprite:
  - Pixels (0..3, 0) return to 00.
  - collision=1.
- Wrap/clip (lores, x=0x42, y=0x1F, n=2, bytes 0xFF 0xFF):
  - Origin is (2, 31); only row 31 is drawn, columns 2..9.
  - Row 32 produces no writes.
- Hires 16x16 (n=0, x=120):
  - Only columns 120..127 are written per row; 32 RAM fetches.
- Two planes (plane_mask=11, n=1, RAM[I]=0x80, RAM[I+1]=0x80):
  - Pixel (x0, y0) goes 00 -> 01 -> 11.
- Control and reset:
  - start pulsed while busy: no effect.
  - reset asserted mid-row: busy=0, vram_we=0 next cycle, collision=0.
